// File: rtl/serial_sum_ctrl.sv
// Sequenced operand summer: one shared adder accumulates NUM_OPS masked operands,
// one per clock, and publishes the registered total with a single-cycle done pulse.
module serial_sum_ctrl #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SUMWIDTH  = 32,
  parameter int unsigned NUM_OPS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [NUM_OPS*DATAWIDTH-1:0]   ops_i,
  input  logic [NUM_OPS-1:0]             en_mask_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [SUMWIDTH-1:0]            final_o
);

  localparam int unsigned IDXW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                               state_q, state_d;
  logic [NUM_OPS-1:0][DATAWIDTH-1:0]    op_q, op_d;
  logic [NUM_OPS-1:0]                   mask_q, mask_d;
  logic [SUMWIDTH-1:0]                  acc_q, acc_d;
  logic [IDXW-1:0]                      idx_q, idx_d;
  logic                                 done_q, done_d;
  logic [SUMWIDTH-1:0]                  final_q, final_d;
  logic [SUMWIDTH-1:0]                  term_c;
  logic [SUMWIDTH-1:0]                  sum_c;

  // Shared adder: the current operand, zeroed when masked out.
  always_comb begin
    term_c = mask_q[idx_q] ? SUMWIDTH'(op_q[idx_q]) : '0;
    sum_c  = acc_q + term_c;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    final_d = final_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = ops_i;
          mask_d  = en_mask_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins even on the last index: no add, no result update.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d = sum_c;
          idx_d = idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            final_d = sum_c;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      final_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      final_q <= final_d;
    end
  end

  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign final_o = final_q;

endmodule

// File: tb/tb_serial_sum_ctrl.sv
// Bench for serial_sum_ctrl: directed scenarios plus random start/abort traffic,
// checked every cycle against a job-level model (total computed at accept time).
module tb_serial_sum_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 32;
  localparam int unsigned N   = 16;
  localparam int unsigned SW8 = 8;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              abort_i;
  logic [N*DW-1:0]   ops_i;
  logic [N-1:0]      en_mask_i;
  logic              busy_o, done_o;
  logic [SW-1:0]     final_o;
  logic              busy8_o, done8_o;
  logic [SW8-1:0]    final8_o;

  int tests;
  int errs;

  serial_sum_ctrl #(.DATAWIDTH(DW), .SUMWIDTH(SW), .NUM_OPS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .ops_i(ops_i), .en_mask_i(en_mask_i),
    .busy_o(busy_o), .done_o(done_o), .final_o(final_o)
  );

  serial_sum_ctrl #(.DATAWIDTH(DW), .SUMWIDTH(SW8), .NUM_OPS(N)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .ops_i(ops_i), .en_mask_i(en_mask_i),
    .busy_o(busy8_o), .done_o(done8_o), .final_o(final8_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] ref_sum(input logic [N*DW-1:0] o, input logic [N-1:0] m);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++)
      if (m[i]) s = s + SW'(o[i*DW +: DW]);
    return s;
  endfunction

  function automatic logic [N*DW-1:0] seq_ops();
    logic [N*DW-1:0] o;
    for (int i = 0; i < int'(N); i++) o[i*DW +: DW] = DW'(i + 1);
    return o;
  endfunction

  function automatic logic [N*DW-1:0] fill_ops(input logic [DW-1:0] v);
    logic [N*DW-1:0] o;
    for (int i = 0; i < int'(N); i++) o[i*DW +: DW] = v;
    return o;
  endfunction

  // Job-level model: a job lasts N cycles unless aborted; its total is known at accept.
  logic          m_busy, m_done;
  logic [SW-1:0] m_final, m_pending;
  int            m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_final = '0; m_pending = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start_i) begin
          m_busy    = 1'b1;
          m_left    = int'(N);
          m_pending = ref_sum(ops_i, en_mask_i);
        end
      end else if (abort_i) begin
        m_busy = 1'b0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_final = m_pending;
        end
      end
    end
  end

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",   SW'(busy_o),   SW'(m_busy));
      check("done",   SW'(done_o),   SW'(m_done));
      check("final",  final_o,       m_final);
      check("busy8",  SW'(busy8_o),  SW'(m_busy));
      check("done8",  SW'(done8_o),  SW'(m_done));
      check("final8", SW'(final8_o), SW'(m_final[SW8-1:0]));
    end
  end

  task automatic start_job(input logic [N*DW-1:0] o, input logic [N-1:0] m);
    @(negedge clk); #1;
    ops_i = o; en_mask_i = m; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
  endtask

  // Returns at the negedge where done is high; cycles counted from the accept edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done_o && cyc < 40) begin
      @(negedge clk);
      if (!done_o) cyc++;
    end
    if (!done_o) begin
      tests++; errs++;
      $display("FAIL wait_done: no done within %0d cycles", cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cyc;

  initial begin
    tests = 0; errs = 0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; ops_i = '0; en_mask_i = '0;
    #12;
    check("rst_busy",  SW'(busy_o), '0);
    check("rst_done",  SW'(done_o), '0);
    check("rst_final", final_o,     '0);
    @(negedge clk); #1 rst_n = 1'b1;
    idle_cycles(2);

    // Sequential operands, full mask.
    start_job(seq_ops(), 16'hFFFF);
    check("busy_after_start", SW'(busy_o), 32'd1);
    wait_done(cyc);
    check("latency_seq", SW'(cyc), 32'd16);
    check("sum_seq", final_o, 32'd136);
    @(negedge clk);
    check("done_one_cycle", SW'(done_o), 32'd0);
    check("final_held", final_o, 32'd136);

    // All 0xFF: full-width total and 8-bit wrap.
    start_job(fill_ops(8'hFF), 16'hFFFF);
    wait_done(cyc);
    check("sum_ff", final_o, 32'h00000FF0);
    check("sum_ff_wrap8", SW'(final8_o), 32'h000000F0);

    // Operand 10 excluded.
    start_job(seq_ops(), 16'hFBFF);
    wait_done(cyc);
    check("sum_masked", final_o, 32'd125);

    // Empty mask still takes the full job length.
    start_job(seq_ops(), 16'h0000);
    wait_done(cyc);
    check("latency_zero_mask", SW'(cyc), 32'd16);
    check("sum_zero_mask", final_o, 32'd0);

    // Start during a run is ignored; then back-to-back start in the done cycle.
    start_job(seq_ops(), 16'hFFFF);
    idle_cycles(4);
    #1;
    ops_i = fill_ops(8'h55); en_mask_i = 16'h00F0; start_i = 1'b1;
    @(negedge clk); #1 start_i = 1'b0;
    wait_done(cyc);
    check("sum_ignore_start", final_o, 32'd136);
    #1;
    ops_i = fill_ops(8'h02); en_mask_i = 16'hFFFF; start_i = 1'b1;
    @(negedge clk); #1 start_i = 1'b0;
    check("b2b_busy", SW'(busy_o), 32'd1);
    wait_done(cyc);
    check("latency_b2b", SW'(cyc), 32'd16);
    check("sum_b2b", final_o, 32'd32);
    idle_cycles(3);

    // Abort at E8 keeps the previous result.
    start_job(seq_ops(), 16'hFFFF);
    wait_done(cyc);
    start_job(fill_ops(8'h11), 16'hFFFF);
    idle_cycles(6);
    #1 abort_i = 1'b1;
    @(negedge clk); #1 abort_i = 1'b0;
    check("abort_busy", SW'(busy_o), 32'd0);
    idle_cycles(20);
    check("abort_final", final_o, 32'd136);

    // Asynchronous reset mid-job.
    start_job(fill_ops(8'h33), 16'hFFFF);
    idle_cycles(6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  SW'(busy_o), '0);
    check("mid_rst_done",  SW'(done_o), '0);
    check("mid_rst_final", final_o,     '0);
    @(negedge clk); #1 rst_n = 1'b1;
    idle_cycles(20);
    check("post_rst_final", final_o, '0);

    // Random traffic: random operands, masks, starts and aborts.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < int'(N); i++) ops_i[i*DW +: DW] = DW'($urandom_range(0, 255));
      en_mask_i = N'($urandom);
      start_i   = ($urandom_range(0, 3) == 0);
      abort_i   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk); #1 start_i = 1'b0; abort_i = 1'b0;
    idle_cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/serial_sum_ctrl.md
# serial_sum_ctrl

Sequenced, resource-shared replacement for a fully unrolled adder-chain summer: one SUMWIDTH-bit adder is scheduled over NUM_OPS unsigned operands, one add per clock, under an FSM. A masked operand contributes zero. The block captures an operand vector on a start pulse and returns the registered sum with a one-cycle done pulse. It sits between the operand source and any consumer of `final`, trading latency for area.

## Interface
- DATAWIDTH, 8, operand width (unsigned)
- SUMWIDTH, 32, accumulator/result width
- NUM_OPS, 16, operands per job (>= 2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a job; sampled only in IDLE
- abort  in  1  cancel a running job; sampled only in RUN
- ops  in  NUM_OPS*DATAWIDTH  packed operands, op[i] = ops[i*DATAWIDTH +: DATAWIDTH]
- en_mask  in  NUM_OPS  bit i = 1 includes op[i], 0 contributes zero
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when `final` is updated
- final  out  SUMWIDTH  last completed sum, held until the next done

## Operation
- States: IDLE, RUN. Internal regs: op_q, mask_q, acc (SUMWIDTH), idx (clog2(NUM_OPS) bits).
- IDLE, start=1: capture ops into op_q and en_mask into mask_q; acc <= 0; idx <= 0; go to RUN. Inputs are not sampled again until the next accepted start.
- IDLE, start=0: hold.
- RUN, abort=0: acc <= acc + (mask_q[idx] ? zero-extend(op_q[idx]) : 0); idx <= idx + 1.
- RUN, idx = NUM_OPS-1, abort=0: final <= acc + term; done <= 1; go to IDLE.
- RUN, abort=1: go to IDLE. No add, no done, `final` unchanged. abort has priority over the last-index completion.
- start in RUN is ignored and not queued. abort in IDLE is ignored.
- Arithmetic: unsigned, zero-extended operands, modulo 2^SUMWIDTH. Wrap is silent; there is no overflow flag.
- All-zero mask: the job still runs NUM_OPS cycles, and final = 0.
- done is registered and deasserts the next cycle unless a new completion occurs.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; acc, idx, op_q, mask_q = 0; busy=0, done=0, final=0. Held while rst=0. Release is synchronous to the next clk edge.
- Reset mid-job: job lost, no done, final=0.
- Start accepted at edge E0: busy=1 after E0.
- Adds occur at edges E1..E_NUM_OPS. Final add and result write at E_NUM_OPS (E16 by default).
- After E_NUM_OPS: done=1, busy=0, new final visible. Latency start-edge to done = NUM_OPS cycles.
- Back-to-back: start high in the done cycle is accepted (state is IDLE). Throughput is one job per NUM_OPS+1 cycles.
- busy is derived from the state register (registered); no combinational path from start or abort to any output.

## Test plan
- op[i] = i+1 (1..16), en_mask = 16'hFFFF, start pulse at E0 -> busy high E0..E16; done pulse exactly after E16; final = 136 (0x00000088).
- All ops = 8'hFF, en_mask = 16'hFFFF -> final = 4080 (0x00000FF0); second identical run with SUMWIDTH = 8 -> final = 8'hF0 (wrap).
- op[i] = i+1, en_mask = 16'hFBFF (operand 10 excluded) -> final = 125. en_mask = 16'h0000 -> final = 0, done still at E16.
- Change ops/en_mask and pulse start at E5 during a run -> result unaffected (136), no second job. Then start in the done cycle with all ops = 2 -> second done 16 cycles later, final = 32.
- abort at E8 -> busy low after E8, no done, final keeps prior value (136). Separately, rst low at E8 -> final=0, busy=0, done=0 immediately (asynchronous), and no done follows.
